// File: rtl/cbus_arbiter_if.sv
// cbus_arbiter bus types and port bundle.
// The package carries the fetch/data bus request and response structs shared by
// the arbiter and its neighbours; the interface groups the six bus signals.
package cbus_arbiter_pkg;
    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

interface cbus_arbiter_if;
    import cbus_arbiter_pkg::*;

    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  oreq;
    dbus_resp_t oresp;

    // The arbiter side: serves both requesters and masters the shared bus.
    modport master (
        input  ireq, dreq, oresp,
        output iresp, dresp, oreq
    );

    // The environment side: requesters plus the external bus slave.
    modport slave (
        output ireq, dreq, oresp,
        input  iresp, dresp, oreq
    );
endinterface

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: two-to-one arbiter sharing the CPU data-bus master port between
// instruction fetch (ireq/iresp) and the memory stage (dreq/dresp).
// Optional feature macro CBUS_ARB_RR_EN: when defined, contention is resolved
// round-robin; when undefined, the memory stage always wins over fetch.
module cbus_arbiter (
    input  logic           clk,
    input  logic           reset,
    cbus_arbiter_if.master bus
);
    import cbus_arbiter_pkg::*;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    state_t    state;
    owner_t    own;
    dbus_req_t rq;

    owner_t    winner;
    owner_t    cur_own;
    logic      any_valid;
    logic      route_en;
    dbus_req_t fetch_req;
    dbus_req_t win_req;

    assign any_valid = bus.ireq.valid | bus.dreq.valid;

`ifdef CBUS_ARB_RR_EN
    owner_t last;

    // Under contention the side that did not win last time is served.
    always_comb begin
        if (bus.ireq.valid && bus.dreq.valid) begin
            winner = (last == OWN_I) ? OWN_D : OWN_I;
        end else if (bus.dreq.valid) begin
            winner = OWN_D;
        end else begin
            winner = OWN_I;
        end
    end

    // Remember who was granted so the other side goes first next time.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last <= OWN_I;
        end else if (state == IDLE && any_valid) begin
            last <= winner;
        end
    end
`else
    // Fixed priority: the memory stage always beats instruction fetch.
    always_comb begin
        winner = bus.dreq.valid ? OWN_D : OWN_I;
    end
`endif

    // Widen a fetch into a full data-bus word read and select the winner.
    always_comb begin
        fetch_req        = '0;
        fetch_req.valid  = bus.ireq.valid;
        fetch_req.addr   = bus.ireq.addr;
        fetch_req.size   = MSIZE4;
        win_req          = (winner == OWN_D) ? bus.dreq : fetch_req;
    end

    // Transaction sequencing; a granted transaction always runs to data_ok.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            own   <= OWN_D;
            rq    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        own <= winner;
                        rq  <= win_req;
                        if (bus.oresp.addr_ok && bus.oresp.data_ok) begin
                            state <= IDLE;
                        end else if (bus.oresp.addr_ok) begin
                            state <= DATA;
                        end else begin
                            state <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (bus.oresp.addr_ok) begin
                        state <= bus.oresp.data_ok ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (bus.oresp.data_ok) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus request: the winner passes straight through in IDLE, the snapshot afterwards.
    always_comb begin
        bus.oreq = '0;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    bus.oreq = win_req;
                end
            end
            ADDR: begin
                bus.oreq       = rq;
                bus.oreq.valid = 1'b1;
            end
            DATA: begin
                bus.oreq       = rq;
                bus.oreq.valid = 1'b0;
            end
            default: bus.oreq = '0;
        endcase
    end

    // Steer the bus response to the owner only; the other side sees zeros.
    always_comb begin
        route_en      = (state != IDLE) || any_valid;
        cur_own       = (state == IDLE) ? winner : own;
        bus.iresp     = '0;
        bus.dresp     = '0;
        if (route_en) begin
            if (cur_own == OWN_D) begin
                bus.dresp = bus.oresp;
            end else begin
                bus.iresp.addr_ok = bus.oresp.addr_ok;
                bus.iresp.data_ok = bus.oresp.data_ok;
                bus.iresp.data    = bus.oresp.data;
            end
        end
    end
endmodule

// File: tb/tb_cbus_arbiter.sv
// Testbench for cbus_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
// Honours CBUS_ARB_RR_EN the same way as the design.
module tb_cbus_arbiter;
    import cbus_arbiter_pkg::*;

    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    cbus_arbiter_if bus ();

    cbus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one outstanding transaction with owner and snapshot.
    logic      m_busy;
    logic      m_acc;
    logic      m_own_d;
    dbus_req_t m_snap;
    logic      g_i;
    logic      g_d;
`ifdef CBUS_ARB_RR_EN
    logic      m_last_d;
`endif

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic dbus_req_t widen(input ibus_req_t r);
        dbus_req_t w;
        w        = '0;
        w.valid  = r.valid;
        w.addr   = r.addr;
        w.size   = MSIZE4;
        return w;
    endfunction

    function automatic logic pick_d();
        if (bus.ireq.valid && bus.dreq.valid) begin
`ifdef CBUS_ARB_RR_EN
            return !m_last_d;
`else
            return 1'b1;
`endif
        end
        return bus.dreq.valid;
    endfunction

    function automatic dbus_req_t exp_oreq();
        dbus_req_t r;
        r = '0;
        if (!m_busy) begin
            if (bus.ireq.valid || bus.dreq.valid)
                r = pick_d() ? bus.dreq : widen(bus.ireq);
        end else if (!m_acc) begin
            r       = m_snap;
            r.valid = 1'b1;
        end
        return r;
    endfunction

    // -1: nobody owns the bus response, 0: fetch, 1: memory stage
    function automatic int exp_owner();
        if (!m_busy) begin
            if (!(bus.ireq.valid || bus.dreq.valid)) return -1;
            return pick_d() ? 1 : 0;
        end
        return m_own_d ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_acc   = 1'b0;
        m_own_d = 1'b1;
        m_snap  = '0;
        g_i     = 1'b0;
        g_d     = 1'b0;
`ifdef CBUS_ARB_RR_EN
        m_last_d = 1'b0;
`endif
    endtask

    task automatic update_model();
        logic pd;
        g_i = 1'b0;
        g_d = 1'b0;
        if (!m_busy) begin
            if (bus.ireq.valid || bus.dreq.valid) begin
                pd      = pick_d();
                m_snap  = pd ? bus.dreq : widen(bus.ireq);
                m_own_d = pd;
`ifdef CBUS_ARB_RR_EN
                m_last_d = pd;
`endif
                g_d     = pd;
                g_i     = !pd;
                m_busy  = !(bus.oresp.addr_ok && bus.oresp.data_ok);
                m_acc   = bus.oresp.addr_ok;
            end
        end else if (!m_acc) begin
            if (bus.oresp.addr_ok) begin
                m_acc = 1'b1;
                if (bus.oresp.data_ok) m_busy = 1'b0;
            end
        end else if (bus.oresp.data_ok) begin
            m_busy = 1'b0;
        end
    endtask

    task automatic check_output(input string tag);
        dbus_req_t  eo;
        ibus_resp_t ei;
        dbus_resp_t ed;
        int         ow;
        eo = exp_oreq();
        ow = exp_owner();
        ei = '0;
        ed = '0;
        if (ow == 0) begin
            ei.addr_ok = bus.oresp.addr_ok;
            ei.data_ok = bus.oresp.data_ok;
            ei.data    = bus.oresp.data;
        end else if (ow == 1) begin
            ed = bus.oresp;
        end
        if (m_busy && m_acc)
            check_val({tag, "_oreq_valid"}, 128'(bus.oreq.valid), 128'(1'b0));
        else
            check_val({tag, "_oreq"}, 128'(bus.oreq), 128'(eo));
        check_val({tag, "_iresp"}, 128'(bus.iresp), 128'(ei));
        check_val({tag, "_dresp"}, 128'(bus.dresp), 128'(ed));
    endtask

    task automatic settle(input string tag);
        #1;
        check_output(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic set_resp(input logic a, input logic d, input logic [31:0] x);
        bus.oresp.addr_ok = a;
        bus.oresp.data_ok = d;
        bus.oresp.data    = x;
    endtask

    task automatic set_dreq(input logic v, input logic [31:0] a, input msize_t s,
                            input logic [3:0] st, input logic [31:0] x);
        bus.dreq.valid  = v;
        bus.dreq.addr   = a;
        bus.dreq.size   = s;
        bus.dreq.strobe = st;
        bus.dreq.data   = x;
    endtask

    logic pend_i;
    logic pend_d;
    logic exp_order [4];

    initial begin
        reset    = 1'b1;
        bus.ireq = '0;
        bus.dreq = '0;
        bus.oresp = '0;
        model_reset();
        @(negedge clk);
        settle("reset");
        check_val("reset_oreq_zero", 128'(bus.oreq), 128'(0));
        @(negedge clk);
        reset = 1'b0;

        // Single fetch: addr_ok in cycle 0, data_ok in cycle 2
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 32'hBFC0_0000;
        set_resp(1'b1, 1'b0, 32'h0);
        settle("fetch_c0");
        check_val("fetch_size", 128'(bus.oreq.size), 128'(MSIZE4));
        check_val("fetch_strobe", 128'(bus.oreq.strobe), 128'(0));
        advance();
        bus.ireq.valid = 1'b0;
        set_resp(1'b0, 1'b0, 32'h0);
        settle("fetch_c1");
        advance();
        set_resp(1'b0, 1'b1, 32'h2408_0001);
        settle("fetch_c2");
        check_val("fetch_data_ok", 128'(bus.iresp.data_ok), 128'(1'b1));
        check_val("fetch_data", 128'(bus.iresp.data), 128'(32'h2408_0001));
        check_val("fetch_dresp_zero", 128'(bus.dresp), 128'(0));
        advance();

        // Load with addr_ok and data_ok in the grant cycle, fetch pending
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 32'hBFC0_0004;
        set_dreq(1'b1, 32'h8000_0004, MSIZE4, 4'h0, 32'h0);
        set_resp(1'b1, 1'b1, 32'h1122_3344);
        settle("same_c0");
        check_val("same_dresp_data_ok", 128'(bus.dresp.data_ok), 128'(1'b1));
        check_val("same_iresp_zero", 128'(bus.iresp), 128'(0));
        advance();
        bus.dreq.valid = 1'b0;
        set_resp(1'b1, 1'b0, 32'h0);
        settle("same_c1");
        check_val("same_fetch_addr", 128'(bus.oreq.addr), 128'(32'hBFC0_0004));
        check_val("same_fetch_valid", 128'(bus.oreq.valid), 128'(1'b1));
        advance();
        bus.ireq.valid = 1'b0;
        set_resp(1'b0, 1'b1, 32'h8C08_0000);
        settle("same_c2");
        advance();

        // Contention: the store goes first, the fetch follows after data_ok
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 32'hBFC0_0008;
        set_dreq(1'b1, 32'h8000_0010, MSIZE4, 4'hF, 32'hDEAD_BEEF);
        set_resp(1'b1, 1'b0, 32'h0);
        settle("cont_c0");
        check_val("cont_store_addr", 128'(bus.oreq.addr), 128'(32'h8000_0010));
        check_val("cont_store_data", 128'(bus.oreq.data), 128'(32'hDEAD_BEEF));
        advance();
        bus.dreq.valid = 1'b0;
        set_resp(1'b0, 1'b0, 32'h0);
        settle("cont_c1");
        advance();
        set_resp(1'b0, 1'b1, 32'h0);
        settle("cont_c2");
        check_val("cont_store_done", 128'(bus.dresp.data_ok), 128'(1'b1));
        advance();
        set_resp(1'b1, 1'b1, 32'hAAAA_5555);
        settle("cont_c3");
        check_val("cont_fetch_addr", 128'(bus.oreq.addr), 128'(32'hBFC0_0008));
        check_val("cont_fetch_data", 128'(bus.iresp.data), 128'(32'hAAAA_5555));
        advance();

        // Address stall with the owner dropping valid after the grant
        bus.ireq.valid = 1'b0;
        set_dreq(1'b1, 32'h8000_0020, MSIZE2, 4'h3, 32'hCAFE_F00D);
        set_resp(1'b0, 1'b0, 32'h0);
        settle("stall_c0");
        advance();
        set_dreq(1'b0, 32'h1234_5678, MSIZE1, 4'h1, 32'h0);
        settle("stall_c1");
        advance();
        settle("stall_c2");
        advance();
        set_resp(1'b1, 1'b0, 32'h0);
        settle("stall_c3");
        check_val("stall_addr", 128'(bus.oreq.addr), 128'(32'h8000_0020));
        check_val("stall_data", 128'(bus.oreq.data), 128'(32'hCAFE_F00D));
        advance();
        set_resp(1'b0, 1'b1, 32'h5A5A_5A5A);
        settle("stall_c4");
        check_val("stall_resp", 128'(bus.dresp.data), 128'(32'h5A5A_5A5A));
        advance();

        // Reset pulse while waiting for data_ok
        set_dreq(1'b1, 32'h8000_0030, MSIZE4, 4'hF, 32'h0102_0304);
        set_resp(1'b1, 1'b0, 32'h0);
        settle("rst_c0");
        advance();
        set_dreq(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
        set_resp(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        model_reset();
        check_output("rst_pulse");
        check_val("rst_oreq_valid", 128'(bus.oreq.valid), 128'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        set_dreq(1'b1, 32'h8000_0040, MSIZE4, 4'h0, 32'h0);
        set_resp(1'b1, 1'b1, 32'h7777_0000);
        settle("rst_after");
        check_val("rst_after_valid", 128'(bus.oreq.valid), 128'(1'b1));
        check_val("rst_after_addr", 128'(bus.oreq.addr), 128'(32'h8000_0040));
        advance();

        // Grant order with both sides continuously valid, starting from reset
        set_dreq(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
        set_resp(1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
`ifdef CBUS_ARB_RR_EN
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_order = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        bus.ireq.valid = 1'b1;
        bus.ireq.addr  = 32'hBFC0_0100;
        set_dreq(1'b1, 32'h8000_0100, MSIZE4, 4'h0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            set_resp(1'b1, 1'b1, 32'h0000_1000 + k);
            settle($sformatf("order%0d", k));
            check_val($sformatf("order%0d_d", k), 128'(bus.dresp.data_ok), 128'(exp_order[k]));
            advance();
        end
        bus.ireq  = '0;
        bus.dreq  = '0;
        bus.oresp = '0;
        settle("order_idle");
        advance();

        // Randomized traffic: requesters hold valid until granted
        pend_i = 1'b0;
        pend_d = 1'b0;
        for (int n = 0; n < 400; n++) begin
            dbus_req_t eo;
            if (!pend_i) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend_i         = 1'b1;
                    bus.ireq.valid = 1'b1;
                    bus.ireq.addr  = {$urandom_range(0, 32'h0FFF_FFFF), 2'b00, 2'b00};
                end else begin
                    bus.ireq.valid = 1'b0;
                    bus.ireq.addr  = $urandom;
                end
            end
            if (!pend_d) begin
                if ($urandom_range(0, 2) == 0) begin
                    pend_d = 1'b1;
                    set_dreq(1'b1, $urandom, msize_t'(3'($urandom_range(0, 2))),
                             4'($urandom_range(0, 15)), $urandom);
                end else begin
                    set_dreq(1'b0, $urandom, MSIZE1, 4'h0, $urandom);
                end
            end
            eo = exp_oreq();
            if (eo.valid) begin
                bus.oresp.addr_ok = 1'($urandom_range(0, 1));
                bus.oresp.data_ok = bus.oresp.addr_ok && ($urandom_range(0, 2) == 0);
            end else if (m_busy && m_acc) begin
                bus.oresp.addr_ok = 1'b0;
                bus.oresp.data_ok = 1'($urandom_range(0, 1));
            end else begin
                bus.oresp.addr_ok = 1'b0;
                bus.oresp.data_ok = 1'b0;
            end
            bus.oresp.data = $urandom;
            settle($sformatf("rand%0d", n));
            advance();
            if (g_i) pend_i = 1'b0;
            if (g_d) pend_d = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cbus_arbiter.md
# cbus_arbiter

Two-to-one arbiter that shares the single data-bus master port of the CPU between instruction fetch (`ireq`/`iresp`) and the memory stage (`dreq`/`dresp`). It sits between the fetch stage, the memory stage and the external bus. It serialises transactions over the split `addr_ok`/`data_ok` handshake and routes each response back to the requester that owns the transaction.

## Interface
Parameters:
- none; all widths come from `ibus_req_t`, `ibus_resp_t`, `dbus_req_t` and `dbus_resp_t`.

Ports:
- `clk  in  1` — single clock; all state updates on the rising edge.
- `reset  in  1` — reset, asynchronous and active-high.
- `ireq  in  ibus_req_t` — fetch request: `valid`, `addr`.
- `iresp  out  ibus_resp_t` — fetch response: `addr_ok`, `data_ok`, `data`.
- `dreq  in  dbus_req_t` — memory-stage request: `valid`, `addr`, `size`, `strobe`, `data`.
- `dresp  out  dbus_resp_t` — memory-stage response.
- `oreq  out  dbus_req_t` — request to the shared bus.
- `oresp  in  dbus_resp_t` — response from the shared bus.

## Operation
- States: `IDLE`, `ADDR` (granted, waiting for `addr_ok`), `DATA` (address accepted, waiting for `data_ok`).
- Owner register `own` holds `I` or `D`. Request register `rq` is a `dbus_req_t` snapshot.
- **IDLE, no valid request:** `oreq = '0`.
- **IDLE, one or both valid:**
  - Pick the winner per Configuration.
  - Drive `oreq` combinationally from the winner in the same cycle.
  - An `ireq` is widened to `size=MSIZE4`, `strobe=0`, `data=0`.
  - At the edge, latch `own` and `rq`.
  - Next state: `DATA` if `oresp.addr_ok`, `IDLE` if both `addr_ok` and `data_ok`, otherwise `ADDR`.
- **ADDR:** `oreq = rq` with `valid=1`. On `addr_ok` go to `DATA`, or to `IDLE` if `data_ok` arrives in the same cycle.
- **DATA:** `oreq.valid=0`. On `data_ok` go to `IDLE`.
- **Response routing:**
  - `oresp.addr_ok`, `oresp.data_ok` and `oresp.data` go only to the owner's response port.
  - In IDLE the owner is the combinational winner; otherwise it is `own`.
  - The non-owner always sees `addr_ok=0`, `data_ok=0`, `data=0`.
- **Dropped requests:** once granted, a transaction always completes. If the owner drops `valid` after grant, the arbiter ignores it; `rq` keeps driving the bus and the response is still delivered.
- **Waiting requester:** the loser in IDLE keeps its `valid` asserted. It is considered again only in the next IDLE cycle, so there is no back-to-back grant within `DATA`.
- **Responses not owed:** a `data_ok` in IDLE or ADDR without a granted transaction is a bus protocol violation and is ignored. The bench asserts it never occurs.

## Timing
- Reset values: state `IDLE`, `own=D`, `rq='0`, round-robin pointer `last=I`. With no input valid, every output is `'0`.
- Grant latency is 0 cycles: the request appears on `oreq` in the same cycle it arrives in IDLE.
- Added response latency is 0: `data_ok` and `data` pass through combinationally.
- Minimum occupancy per transaction is 1 cycle (`addr_ok` and `data_ok` both in the grant cycle). The next grant can occur in the following cycle.
- A `reset` asserted mid-transaction forces IDLE immediately and discards the transaction. The external bus must be reset together with the arbiter.

## Configuration
- `CBUS_ARB_RR_EN`
  - Defined: round-robin. When both requesters are valid in IDLE, the winner is the side opposite `last`. `last` updates to the winner at each grant edge.
  - Undefined: fixed priority, `dreq` always wins over `ireq`. `last` is not implemented.

## Test plan
- Single fetch: `ireq.valid=1`, `addr=0xBFC0_0000`; bus gives `addr_ok` at cycle 0 and `data_ok` at cycle 2 with `data=0x2408_0001` → `oreq.size=MSIZE4`, `strobe=0`; `iresp.data_ok=1` with `data=0x2408_0001` at cycle 2; `dresp` stays all zeros.
- Contention, fixed priority: both valid, `dreq` is `SW 0x8000_0010 data=0xDEAD_BEEF strobe=0xF` → the store is served first. The fetch is granted in the first IDLE cycle after the store's `data_ok`.
- Contention with `CBUS_ARB_RR_EN`: both continuously valid for 4 transactions → grant order D, I, D, I (`last=I` at reset).
- Address stall: `addr_ok` held low for 3 cycles; the owner drops `valid` in cycle 1 → `oreq` keeps the original addr/data through cycle 3. The response is delivered to the owner.
- Same-cycle `addr_ok` and `data_ok` on a load to `0x8000_0004` → `dresp.data_ok=1` in the grant cycle; the state is IDLE next cycle; a pending fetch is granted at cycle 1.
- `reset` pulse while in `DATA` → `oreq.valid=0` immediately; after release, state is IDLE and a new `dreq` is granted.
